// File: rtl/dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl
//   CPU-side initiator for the data-memory port. Converts MEM-stage load/store
//   requests into DM_enable/DM_read/DM_write phases, waits for DM_finish, and
//   checks DM_resp. Byte and halfword stores are read-modify-write. Loads are
//   lane-extracted and then sign- or zero-extended.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_*             MEM-stage request (valid, write, size, unsigned, byte addr, wdata)
//   stall             hold the pipeline while a request is pending and unanswered
//   rsp_valid         one-cycle completion pulse; rsp_rdata / rsp_err valid with it
//   DM_enable/read/write/addr/in   registered drive of the data-memory port
//   DM_out/ready/resp/finish       data-memory return path
// -----------------------------------------------------------------------------
module dm_access_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int TIMEOUT   = 15,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              DM_enable,
  output logic              DM_read,
  output logic              DM_write,
  output logic [ADDR_W-1:0] DM_addr,
  output logic [DATA_W-1:0] DM_in,
  input  logic [DATA_W-1:0] DM_out,
  input  logic              DM_ready,
  input  logic [1:0]        DM_resp,
  input  logic              DM_finish
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_REL, S_WR, S_DONE} state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_RETRY = 2'b10;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

  state_t            r_state;
  logic              r_dm_enable, r_dm_read, r_dm_write;
  logic [ADDR_W-1:0] r_dm_addr;
  logic [DATA_W-1:0] r_dm_in;
  logic              r_rsp_valid, r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [RTY_W-1:0]  r_retry_cnt;
  // Latched request: the transaction runs to completion even if req_valid drops.
  logic              r_write, r_unsigned, r_rel_to_wr;
  logic [1:0]        r_size, r_lane;
  logic [DATA_W-1:0] r_wdata;

  logic              w_misaligned;
  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_shifted, w_load_data, w_mask, w_merged;

  assign w_misaligned = (req_size == 2'b11)
                      | ((req_size == 2'b01) & req_addr[0])
                      | ((req_size == 2'b10) & (|req_addr[1:0]));

  // Little-endian lanes: the shift is 8 * byte offset. Halfwords are aligned,
  // so the same shift also selects the correct half.
  assign w_shamt   = {r_lane, 3'b000};
  assign w_shifted = DM_out >> w_shamt;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_load_data = DM_out;
    w_mask      = {DATA_W{1'b1}};
    unique case (r_size)
      2'b00: begin
        w_load_data = {{(DATA_W-8){~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
        w_mask      = DATA_W'(8'hFF) << w_shamt;
      end
      2'b01: begin
        w_load_data = {{(DATA_W-16){~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
        w_mask      = DATA_W'(16'hFFFF) << w_shamt;
      end
      default: ;
    endcase
  end

  // Sub-word store merge: only the addressed lanes take new data.
  assign w_merged = (DM_out & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

  // Stall drops in the response cycle so the pipeline advances with the result.
  assign stall = ~rst & req_valid & ~r_rsp_valid;

  assign DM_enable = r_dm_enable;
  assign DM_read   = r_dm_read;
  assign DM_write  = r_dm_write;
  assign DM_addr   = r_dm_addr;
  assign DM_in     = r_dm_in;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dm_enable <= 1'b0;
      r_dm_read   <= 1'b0;
      r_dm_write  <= 1'b0;
      r_dm_addr   <= '0;
      r_dm_in     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_tmo_cnt   <= '0;
      r_retry_cnt <= '0;
      r_write     <= 1'b0;
      r_unsigned  <= 1'b0;
      r_rel_to_wr <= 1'b0;
      r_size      <= '0;
      r_lane      <= '0;
      r_wdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid && DM_ready) begin
            r_write     <= req_write;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_lane      <= req_addr[1:0];
            r_wdata     <= req_wdata;
            r_dm_addr   <= req_addr[ADDR_W+1:2];
            r_tmo_cnt   <= '0;
            r_retry_cnt <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            if (w_misaligned) begin
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_DONE;
            end else if (req_write && (req_size == 2'b10)) begin
              r_dm_in     <= req_wdata;
              r_dm_enable <= 1'b1;
              r_dm_write  <= 1'b1;
              r_state     <= S_WR;
            end else begin
              r_dm_enable <= 1'b1;
              r_dm_read   <= 1'b1;
              r_state     <= S_RD;
            end
          end
        end

        S_RD, S_WR: begin
          if (DM_finish) begin
            // Every response closes the current phase.
            r_tmo_cnt   <= '0;
            r_dm_enable <= 1'b0;
            r_dm_read   <= 1'b0;
            r_dm_write  <= 1'b0;
            case (DM_resp)
              RESP_OKAY: begin
                if (r_state == S_RD && r_write) begin
                  r_dm_in     <= w_merged;
                  r_rel_to_wr <= 1'b1;
                  r_state     <= S_REL;
                end else begin
                  if (!r_write) r_rsp_rdata <= w_load_data;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_DONE;
                end
              end
              RESP_RETRY: begin
                if (r_retry_cnt == RTY_LAST) begin
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_DONE;
                end else begin
                  r_retry_cnt <= r_retry_cnt + 1'b1;
                  r_rel_to_wr <= (r_state == S_WR);
                  r_state     <= S_REL;
                end
              end
              // ERROR and SPLIT abort; a pending RMW write is never issued.
              default: begin
                r_rsp_err   <= 1'b1;
                r_rsp_valid <= 1'b1;
                r_state     <= S_DONE;
              end
            endcase
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_dm_enable <= 1'b0;
            r_dm_read   <= 1'b0;
            r_dm_write  <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        // One idle cycle lets the memory drop DM_finish before the next phase.
        S_REL: begin
          r_dm_enable <= 1'b1;
          r_dm_read   <= ~r_rel_to_wr;
          r_dm_write  <= r_rel_to_wr;
          r_state     <= r_rel_to_wr ? S_WR : S_RD;
        end

        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_access_ctrl
//   Directed bench for dm_access_ctrl. A behavioural data-memory model answers
//   one cycle after it first sees DM_enable, and can be told to RETRY, ERROR, or
//   hang. Each stimulus pushes its expected response into exp_q and any expected
//   memory write into wr_q. A forked monitor pops these queues whenever the DUT
//   presents a response or completes a write.
// -----------------------------------------------------------------------------
module tb_dm_access_ctrl;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 12;
  localparam int TIMEOUT   = 15;
  localparam int MAX_RETRY = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [13:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        DM_enable, DM_read, DM_write;
  logic [11:0] DM_addr;
  logic [31:0] DM_in;
  logic [31:0] DM_out = '0;
  logic        DM_ready = 1'b1;
  logic [1:0]  DM_resp = 2'b00;
  logic        DM_finish = 1'b0;

  always #5 clk = ~clk;

  dm_access_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
    .DM_addr(DM_addr), .DM_in(DM_in), .DM_out(DM_out), .DM_ready(DM_ready),
    .DM_resp(DM_resp), .DM_finish(DM_finish)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
    int          at_cyc;   // expected response cycle, -1 = don't care
  } exp_t;
  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   n_total = 0, n_bad = 0;
  int   cyc = 0, n_en = 0, n_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- data-memory model ----------------
  logic [31:0] mem [0:4095];
  int m_req_id = 0, m_seen_id = 0, m_retry_given = 0, m_retry_cfg = 0;
  bit m_hang = 1'b0, m_err_resp = 1'b0;
  int m_given_eff;
  // The retry budget restarts with each new request.
  assign m_given_eff = (m_seen_id == m_req_id) ? m_retry_given : 0;

  always @(posedge clk) begin
    m_seen_id     <= m_req_id;
    m_retry_given <= m_given_eff;
    if (DM_enable && !DM_finish && !m_hang) begin
      DM_finish <= 1'b1;
      if (m_err_resp) begin
        DM_resp <= 2'b01;
      end else if (m_given_eff < m_retry_cfg) begin
        DM_resp       <= 2'b10;
        m_retry_given <= m_given_eff + 1;
      end else begin
        DM_resp <= 2'b00;
        if (DM_write) mem[DM_addr] <= DM_in;
        else          DM_out       <= mem[DM_addr];
      end
    end else begin
      DM_finish <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic prev_en;
    exp_t e;
    wr_t  w;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (DM_enable && !prev_en) n_en++;
        if (DM_enable && DM_write && DM_finish && DM_resp == 2'b00) begin
          n_wr++;
          if (wr_q.size() == 0) check("unexpected_write", 1, 0);
          else begin
            w = wr_q.pop_front();
            check("wr_addr", 32'(DM_addr), 32'(w.addr));
            check("wr_data", DM_in, w.data);
          end
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            if (e.chk_rd) check("rsp_rdata", rsp_rdata, e.rd);
            if (e.at_cyc >= 0) check("rsp_cycle", cyc, e.at_cyc);
          end
        end
      end
      prev_en = DM_enable;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [13:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    m_req_id     = m_req_id + 1;
  endtask

  task automatic push_exp(input logic wr, input logic [31:0] rd, input logic err, input int lat);
    exp_t e;
    e.rd     = rd;
    e.err    = err;
    e.chk_rd = !wr && !err;
    e.at_cyc = (lat > 0) ? cyc + lat : -1;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic wait_rsp();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("rsp_arrival", 0, 1);
      exp_q.delete();
    end else if (req_valid) begin
      check("stall_on_rsp", 32'(stall), 0);
    end
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [13:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat,
                       input bit drop = 1'b0);
    @(negedge clk);
    drive(wr, sz, uns, a, wd);
    push_exp(wr, exp_rd, exp_err, lat);
    if (drop) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    wait_rsp();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int en0, wr0;
    fork
      monitor();
    join_none

    // Reset with a request pending: everything quiet, no stall.
    drive(1'b0, 2'b10, 1'b0, 14'h010, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_strobes", 32'({DM_enable, DM_read, DM_write}), 0);
    check("rst_rsp", 32'({rsp_valid, rsp_err}), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_addr_in", 32'(DM_addr) | DM_in, 0);
    check("rst_rdata", rsp_rdata, 0);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Word store/load round trip at byte 0x010, word address 4.
    push_wr(12'd4, 32'hDEADBEEF);
    issue(1'b1, 2'b10, 1'b0, 14'h010, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    // Byte RMW over 0x11223344, then signed and unsigned byte loads.
    push_wr(12'd8, 32'h11223344);
    issue(1'b1, 2'b10, 1'b0, 14'h020, 32'h11223344, 32'h0, 1'b0, 3);
    push_wr(12'd8, 32'hAA223344);
    issue(1'b1, 2'b00, 1'b0, 14'h023, 32'h000000AA, 32'h0, 1'b0, 6);
    issue(1'b0, 2'b00, 1'b0, 14'h023, 32'h0, 32'hFFFFFFAA, 1'b0, 3);
    issue(1'b0, 2'b00, 1'b1, 14'h023, 32'h0, 32'h000000AA, 1'b0, 3);

    // Halfword loads of 0x80011234, a byte from lane 1, and a halfword RMW.
    push_wr(12'd12, 32'h80011234);
    issue(1'b1, 2'b10, 1'b0, 14'h030, 32'h80011234, 32'h0, 1'b0, 3);
    issue(1'b0, 2'b01, 1'b0, 14'h032, 32'h0, 32'hFFFF8001, 1'b0, 3);
    issue(1'b0, 2'b01, 1'b1, 14'h032, 32'h0, 32'h00008001, 1'b0, 3);
    issue(1'b0, 2'b01, 1'b0, 14'h030, 32'h0, 32'h00001234, 1'b0, 3);
    issue(1'b0, 2'b00, 1'b0, 14'h031, 32'h0, 32'h00000012, 1'b0, 3);
    push_wr(12'd12, 32'h8001BEEF);
    issue(1'b1, 2'b01, 1'b0, 14'h030, 32'h0000BEEF, 32'h0, 1'b0, 6);
    issue(1'b0, 2'b10, 1'b0, 14'h030, 32'h0, 32'h8001BEEF, 1'b0, 3);

    // Misaligned accesses: immediate error, no DM phase.
    en0 = n_en;
    issue(1'b0, 2'b01, 1'b0, 14'h011, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b10, 1'b0, 14'h012, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b11, 1'b0, 14'h010, 32'h0, 32'h0, 1'b1, 1);
    check("misaligned_no_enable", n_en - en0, 0);

    // RETRY twice then OKAY: two reissues, good data.
    en0 = n_en;
    m_retry_cfg = 2;
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 32'hDEADBEEF, 1'b0, 9);
    check("retry2_phases", n_en - en0, 3);

    // RETRY three times on the read of a byte RMW: error, write never issued.
    en0 = n_en;
    wr0 = n_wr;
    m_retry_cfg = 3;
    issue(1'b1, 2'b00, 1'b0, 14'h010, 32'h00000055, 32'h0, 1'b1, 9);
    m_retry_cfg = 0;
    check("retry3_phases", n_en - en0, 3);
    check("retry3_no_write", n_wr - wr0, 0);
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    // ERROR on the read of a byte RMW: error, word unchanged.
    wr0 = n_wr;
    m_err_resp = 1'b1;
    issue(1'b1, 2'b00, 1'b0, 14'h020, 32'h00000077, 32'h0, 1'b1, 3);
    m_err_resp = 1'b0;
    check("error_no_write", n_wr - wr0, 0);
    issue(1'b0, 2'b00, 1'b1, 14'h023, 32'h0, 32'h000000AA, 1'b0, 3);

    // Half RMW with req_valid dropped right after accept still completes.
    push_wr(12'd8, 32'h5A5A3344);
    issue(1'b1, 2'b01, 1'b0, 14'h022, 32'h00005A5A, 32'h0, 1'b0, 6, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 14'h020, 32'h0, 32'h5A5A3344, 1'b0, 3);

    // Memory never finishes: timeout error.
    m_hang = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 32'h0, 1'b1, TIMEOUT + 1);
    m_hang = 1'b0;

    // Reset during the write phase: strobes drop and no response follows.
    wr0 = n_wr;
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 14'h040, 32'h12345678);
    @(negedge clk);
    check("wr_phase_active", 32'({DM_enable, DM_write}), 32'h3);
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_strobes", 32'({DM_enable, DM_read, DM_write}), 0);
    check("rst_mid_rsp", 32'(rsp_valid), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_write", n_wr - wr0, 0);
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    // DM_ready low: no DM phase, stall held until ready rises.
    en0 = n_en;
    DM_ready = 1'b0;
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 14'h010, 32'h0);
    push_exp(1'b0, 32'hDEADBEEF, 1'b0, -1);
    repeat (4) begin
      @(negedge clk);
      check("stall_not_ready", 32'(stall), 1);
      check("enable_not_ready", 32'(DM_enable), 0);
    end
    DM_ready = 1'b1;
    wait_rsp();
    check("enable_after_ready", n_en - en0, 1);

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
